seg7_scan_mux: RTL
==================

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with clock and reset ports named as the codebase names them (CLK, RST).
REQ-002 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-003 Parameter SLOT_CYCLES, default 32768: CLK cycles per digit slot, minimum 32.
REQ-004 Parameter BLANK_CYCLES, default 8192: dead-time cycles at the start of each slot, legal range 1..SLOT_CYCLES-16.
REQ-005 Parameter ACTIVE_LOW, default 1: 1 means SEG and SEG_CS drive 0 to light or select.
REQ-006 Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- LOAD  in  1  single-cycle request to capture new display data.
- DIGITS  in  NUM_DIGITS*4  hex value per digit; digit k is at [4k+3:4k].
- DP  in  NUM_DIGITS  decimal point per digit.
- BLANK_MASK  in  NUM_DIGITS  1 forces digit k dark.
- BRIGHT  in  4  brightness level; present only under SEG7_BRIGHTNESS_EN.
- SEG  out  8  segments; bit0..6 = A..G, bit7 = DP.
- SEG_CS  out  NUM_DIGITS  one-hot digit select.
- DIGIT_IDX  out  3  index of the current slot.
- LOAD_ACK  out  1  one-cycle pulse when pending data becomes displayed.
- FRAME_DONE  out  1  one-cycle pulse at the end of the final slot.

Function
REQ-007 slot_cnt SHALL count 0..SLOT_CYCLES-1 and wrap to 0; DIGIT_IDX SHALL increment on each wrap, going from NUM_DIGITS-1 back to 0.
REQ-008 The two-state FSM SHALL be BLANK while slot_cnt < BLANK_CYCLES and ON otherwise; slot wrap SHALL return it to BLANK.
REQ-009 In BLANK, every SEG_CS SHALL be inactive and SEG all-off.
REQ-010 In ON, SEG_CS[DIGIT_IDX] SHALL be active only, unless BLANK_MASK_d[DIGIT_IDX]=1, in which case no select is active.
REQ-011 SEG SHALL be the hex decode of the displayed digit, with bit7 = DP, and polarity per ACTIVE_LOW; with ACTIVE_LOW=1 and DP=0, values 1/2/3 SHALL give 0xF9/0xA4/0xB0.
REQ-012 SEG and SEG_CS SHALL be registered: the value in cycle t+1 is a function of the state in cycle t.
REQ-013 LOAD SHALL copy DIGITS, DP and BLANK_MASK into a pending register and set pending; LOAD while pending is set SHALL overwrite the pending data (last wins).
REQ-014 At the frame boundary (DIGIT_IDX wraps to 0) with pending set, pending data SHALL move to the display register, pending SHALL clear, and LOAD_ACK SHALL pulse in that cycle.
REQ-015 A LOAD coinciding with the boundary cycle SHALL transfer the previously pending data and hold the new data pending for the next frame.
REQ-016 FRAME_DONE SHALL pulse when slot_cnt = SLOT_CYCLES-1 and DIGIT_IDX = NUM_DIGITS-1.

Reset
REQ-017 On RST, slot_cnt and DIGIT_IDX SHALL be 0, the FSM SHALL be in BLANK, and pending SHALL be clear.
REQ-018 On RST, the display register SHALL hold digits 0 with all BLANK_MASK bits set; SEG and SEG_CS SHALL be inactive; LOAD_ACK and FRAME_DONE SHALL be 0.
REQ-019 Reset asserted mid-slot SHALL take effect immediately and SHALL discard pending data.

Configuration
REQ-020 With SEG7_BRIGHTNESS_EN defined, in ON the select SHALL be active only while on_cnt[3:0] < BRIGHT (on_cnt = slot_cnt - BLANK_CYCLES), so BRIGHT=0 means dark; (SLOT_CYCLES-BLANK_CYCLES) SHALL be a multiple of 16.
REQ-021 Without SEG7_BRIGHTNESS_EN, the BRIGHT port SHALL be absent and the select SHALL be active for the whole ON phase.

Structure
REQ-022 Package seg7_pkg SHALL hold the FSM state typedef, the 16-entry active-high hex segment table, and the SEG bit-position constants.
REQ-023 Combinational sub-module seg7_hex_decode (4-bit value in, 7-bit active-high segments out) SHALL be instantiated once; polarity inversion SHALL be done in seg7_scan_mux.

Verification (NUM_DIGITS=4, SLOT_CYCLES=64, BLANK_CYCLES=16, ACTIVE_LOW=1)
REQ-024 Release reset, no LOAD -> SEG=0xFF and SEG_CS=4'hF for a full frame; FRAME_DONE pulses every 256 cycles.
REQ-025 LOAD DIGITS=16'h3210, DP=0, mask=0 -> LOAD_ACK at next boundary; then per slot, 16 cycles all-off followed by 48 cycles with SEG=0xC0/0xF9/0xA4/0xB0 and SEG_CS=1110/1101/1011/0111.
REQ-026 Two LOADs in one frame (16'h1111 then 16'h2222) -> single LOAD_ACK; the displayed value is 2222.
REQ-027 LOAD in the boundary cycle -> LOAD_ACK transfers older data; new data appears one frame (256 cycles) later with a second LOAD_ACK.
REQ-028 SEG7_BRIGHTNESS_EN with BRIGHT=4 -> in ON the select is active 4 of every 16 cycles; BRIGHT=0 -> SEG_CS stays 4'hF.
REQ-029 RST asserted at slot 2, slot_cnt 30 with pending set -> outputs inactive next edge; after release, no LOAD_ACK is produced.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer:
// FSM state, active-high hex segment table and SEG bit positions.
package seg7_pkg;

   typedef enum logic {
      StBlank,
      StOn
   } seg7_state_e;

   localparam int unsigned SegA  = 0;
   localparam int unsigned SegB  = 1;
   localparam int unsigned SegC  = 2;
   localparam int unsigned SegD  = 3;
   localparam int unsigned SegE  = 4;
   localparam int unsigned SegF  = 5;
   localparam int unsigned SegG  = 6;
   localparam int unsigned SegDp = 7;

   // Entry k lights the glyph for hex value k; bit0..6 = A..G, 1 = lit.
   localparam logic [15:0][6:0] HexSegTable = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Data/display bundle between a display client and seg7_scan_mux.
// BRIGHT exists only when SEG7_BRIGHTNESS_EN is defined.
interface seg7_scan_mux_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                    LOAD;
   logic [NUM_DIGITS*4-1:0] DIGITS;
   logic [NUM_DIGITS-1:0]   DP;
   logic [NUM_DIGITS-1:0]   BLANK_MASK;
`ifdef SEG7_BRIGHTNESS_EN
   logic [3:0]              BRIGHT;
`endif
   logic [7:0]              SEG;
   logic [NUM_DIGITS-1:0]   SEG_CS;
   logic [2:0]              DIGIT_IDX;
   logic                    LOAD_ACK;
   logic                    FRAME_DONE;

   modport master (
`ifdef SEG7_BRIGHTNESS_EN
      output BRIGHT,
`endif
      output LOAD, DIGITS, DP, BLANK_MASK,
      input  SEG, SEG_CS, DIGIT_IDX, LOAD_ACK, FRAME_DONE
   );

   modport slave (
`ifdef SEG7_BRIGHTNESS_EN
      input  BRIGHT,
`endif
      input  LOAD, DIGITS, DP, BLANK_MASK,
      output SEG, SEG_CS, DIGIT_IDX, LOAD_ACK, FRAME_DONE
   );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder, active-high segments A..G.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] value_i,
   output logic [6:0] seg_o
);

   assign seg_o = HexSegTable[value_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment driver with frame-synchronous data update.
// Optional macro SEG7_BRIGHTNESS_EN adds the BRIGHT duty-cycle control.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SLOT_CYCLES  = 32768,
   parameter int unsigned BLANK_CYCLES = 8192,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input logic            CLK,
   input logic            RST,
   seg7_scan_mux_if.slave bus
);

   localparam int unsigned         CntW      = $clog2(SLOT_CYCLES);
   localparam logic [CntW-1:0]     SlotLast  = CntW'(SLOT_CYCLES - 1);
   localparam logic [CntW-1:0]     BlankLast = CntW'(BLANK_CYCLES - 1);
   localparam logic [2:0]          IdxLast   = 3'(NUM_DIGITS - 1);
   localparam logic [7:0]          SegOff    = {8{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] CsOff   = {NUM_DIGITS{ACTIVE_LOW}};

   logic [CntW-1:0]         slot_cnt_q, slot_cnt_d;
   logic [2:0]              digit_idx_q, digit_idx_d;
   seg7_state_e             state_q, state_d;
   logic                    slot_end, frame_end, load_ack;

   logic                    pending_q, pending_d;
   logic [NUM_DIGITS*4-1:0] pend_digits_q, disp_digits_q;
   logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q;
   logic [NUM_DIGITS-1:0]   pend_mask_q, disp_mask_q;

   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   seg_cs_q, seg_cs_d;

   logic [3:0]              cur_digit;
   logic [NUM_DIGITS-1:0]   dp_shift, mask_shift, cs_onehot;
   logic [6:0]              hex_seg;
   logic                    lit_phase;

   assign slot_end  = (slot_cnt_q == SlotLast);
   assign frame_end = slot_end && (digit_idx_q == IdxLast);
   assign load_ack  = frame_end && pending_q;

   always_comb begin
      slot_cnt_d  = slot_end ? '0 : slot_cnt_q + 1'b1;
      digit_idx_d = digit_idx_q;
      if (slot_end) begin
         digit_idx_d = (digit_idx_q == IdxLast) ? 3'd0 : digit_idx_q + 3'd1;
      end
   end

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StBlank;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: tracks whether the next slot_cnt lies in the dead time
   always_comb begin
      state_d = state_q;
      if (slot_end) begin
         state_d = StBlank;
      end else if (slot_cnt_q == BlankLast) begin
         state_d = StOn;
      end
   end

`ifdef SEG7_BRIGHTNESS_EN
   logic [CntW-1:0] on_cnt;
   assign on_cnt    = slot_cnt_q - CntW'(BLANK_CYCLES);
   assign lit_phase = (on_cnt[3:0] < bus.BRIGHT);
`else
   assign lit_phase = 1'b1;
`endif

   // Shifts rather than variable part-selects keep the index width generic.
   assign cur_digit  = 4'(disp_digits_q >> {digit_idx_q, 2'b00});
   assign dp_shift   = disp_dp_q >> digit_idx_q;
   assign mask_shift = disp_mask_q >> digit_idx_q;
   assign cs_onehot  = NUM_DIGITS'(1) << digit_idx_q;

   seg7_hex_decode u_hex_decode (
      .value_i (cur_digit),
      .seg_o   (hex_seg)
   );

   // FSM outputs, registered below; XOR with the off pattern applies polarity
   always_comb begin
      seg_d    = SegOff;
      seg_cs_d = CsOff;
      if (state_q == StOn && !mask_shift[0] && lit_phase) begin
         seg_d    = {dp_shift[0], hex_seg} ^ SegOff;
         seg_cs_d = cs_onehot ^ CsOff;
      end
   end

   always_comb begin
      pending_d = pending_q;
      if (frame_end) begin
         pending_d = 1'b0;
      end
      if (bus.LOAD) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         slot_cnt_q    <= '0;
         digit_idx_q   <= '0;
         pending_q     <= 1'b0;
         pend_digits_q <= '0;
         pend_dp_q     <= '0;
         pend_mask_q   <= '0;
         disp_digits_q <= '0;
         disp_dp_q     <= '0;
         disp_mask_q   <= '1;
         seg_q         <= SegOff;
         seg_cs_q      <= CsOff;
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         digit_idx_q <= digit_idx_d;
         pending_q   <= pending_d;
         if (bus.LOAD) begin
            pend_digits_q <= bus.DIGITS;
            pend_dp_q     <= bus.DP;
            pend_mask_q   <= bus.BLANK_MASK;
         end
         if (load_ack) begin
            disp_digits_q <= pend_digits_q;
            disp_dp_q     <= pend_dp_q;
            disp_mask_q   <= pend_mask_q;
         end
         seg_q    <= seg_d;
         seg_cs_q <= seg_cs_d;
      end
   end

   assign bus.SEG        = seg_q;
   assign bus.SEG_CS     = seg_cs_q;
   assign bus.DIGIT_IDX  = digit_idx_q;
   assign bus.LOAD_ACK   = load_ack;
   assign bus.FRAME_DONE = frame_end;

endmodule
